// File: rtl/motor_pasos_prog_if.sv
// Bus bundle for the programmable stepper driver:
// move request, drive options and status/coil outputs.
interface motor_pasos_prog_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int POS_W = 16
);
    logic             en;
    logic [1:0]       mode;
    logic             sentido;
    logic [DIV_W-1:0] period;
    logic             start;
    logic [CNT_W-1:0] steps;
    logic             abort;
    logic             busy;
    logic             done;
    logic [3:0]       coils;
    logic [POS_W-1:0] position;

    modport master (
        output en, mode, sentido, period, start, steps, abort,
        input  busy, done, coils, position
    );

    modport slave (
        input  en, mode, sentido, period, start, steps, abort,
        output busy, done, coils, position
    );
endinterface

// File: rtl/motor_pasos_prog.sv
// Programmable stepper-motor move controller: wave/full/half
// stepping, divided step rate, step counting and abort.
module motor_pasos_prog #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16,
    parameter int POS_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    motor_pasos_prog_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nx;
    logic [2:0]       idx, idx_nx;
    logic [DIV_W-1:0] divider, divider_nx;
    logic [CNT_W-1:0] remaining, rem_nx;
    logic [POS_W-1:0] position, pos_nx;
    logic             done, done_nx;
    logic [3:0]       coils;
    logic             big;
    logic [2:0]       mag;

    function automatic logic [3:0] phase_tbl(input logic [2:0] i);
        logic [3:0] c;
        c = 4'b0000;
        unique case (i)
            3'd0: c = 4'b1000;
            3'd1: c = 4'b1100;
            3'd2: c = 4'b0100;
            3'd3: c = 4'b0110;
            3'd4: c = 4'b0010;
            3'd5: c = 4'b0011;
            3'd6: c = 4'b0001;
            3'd7: c = 4'b1001;
        endcase
        return c;
    endfunction

    // Wave wants even idx, full wants odd; a mismatch realigns by one.
    assign big = ~bus.mode[1] && (idx[0] == bus.mode[0]);
    assign mag = big ? 3'd2 : 3'd1;

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        divider_nx = divider;
        rem_nx     = remaining;
        pos_nx     = position;
        done_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    divider_nx = '0;
                    if (bus.steps == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        rem_nx   = bus.steps;
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    rem_nx   = '0;
                    state_nx = IDLE;
                end else if (bus.en) begin
                    if (divider == bus.period) begin
                        divider_nx = '0;
                        idx_nx = bus.sentido ? idx - mag : idx + mag;
                        pos_nx = bus.sentido ? position - POS_W'(1)
                                             : position + POS_W'(1);
                        rem_nx = remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end
                    end else begin
                        divider_nx = divider + DIV_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            idx       <= 3'd0;
            divider   <= '0;
            remaining <= '0;
            position  <= '0;
            done      <= 1'b0;
            coils     <= 4'b0000;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            divider   <= divider_nx;
            remaining <= rem_nx;
            position  <= pos_nx;
            done      <= done_nx;
            coils     <= bus.en ? phase_tbl(idx) : 4'b0000;
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = done;
    assign bus.coils    = coils;
    assign bus.position = position;
endmodule

// File: tb/tb_motor_pasos_prog.sv
// Scoreboard bench for motor_pasos_prog: directed scenarios plus
// random traffic checked against a step-level behavioural model.
module tb_motor_pasos_prog;
    localparam int DIV_W = 16;
    localparam int CNT_W = 16;
    localparam int POS_W = 16;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [3:0]  coils;
        logic [15:0] position;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;
    exp_t exp_q[$];

    motor_pasos_prog_if #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) b ();

    motor_pasos_prog #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive values for the next cycle
    bit       d_rst;
    bit       d_en;
    bit [1:0] d_mode;
    bit       d_sd;
    int       d_per;
    bit       d_start;
    int       d_steps;
    bit       d_abort;

    // Behavioural model: motor angle in half-steps, step budget, time
    bit m_busy;
    int m_rem;
    int m_wait;
    int m_phase;
    int m_pos;
    bit [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

    function automatic int wrap8(input int p);
        return ((p % 8) + 8) % 8;
    endfunction

    task automatic model_step(input bit sd, input bit [1:0] md);
        int dir;
        int want;
        dir = sd ? -1 : 1;
        if (md[1]) begin
            m_phase = wrap8(m_phase + dir);
        end else begin
            want = md[0];
            if ((m_phase % 2) == want) m_phase = wrap8(m_phase + 2 * dir);
            else m_phase = wrap8(m_phase + dir);
        end
        m_pos = (m_pos + dir) & 16'hFFFF;
        m_rem = m_rem - 1;
    endtask

    task automatic cyc();
        exp_t e;
        @(negedge clk);
        rst       = d_rst;
        b.en      = d_en;
        b.mode    = d_mode;
        b.sentido = d_sd;
        b.period  = DIV_W'(d_per);
        b.start   = d_start;
        b.steps   = CNT_W'(d_steps);
        b.abort   = d_abort;
        e.done = 1'b0;
        if (!d_rst) begin
            m_busy = 0; m_rem = 0; m_wait = 0; m_phase = 0; m_pos = 0;
            e.coils = 4'b0000;
        end else begin
            e.coils = d_en ? tbl[m_phase] : 4'b0000;
            if (m_busy) begin
                if (d_abort) begin
                    m_busy = 0;
                    m_rem  = 0;
                end else if (d_en) begin
                    m_wait = m_wait + 1;
                    if (m_wait == d_per + 1) begin
                        m_wait = 0;
                        model_step(d_sd, d_mode);
                        if (m_rem == 0) begin
                            m_busy = 0;
                            e.done = 1'b1;
                        end
                    end
                end
            end else if (d_start && !d_abort) begin
                m_wait = 0;
                if (d_steps == 0) e.done = 1'b1;
                else begin
                    m_busy = 1;
                    m_rem  = d_steps;
                end
            end
        end
        e.busy     = m_busy;
        e.position = 16'(m_pos);
        exp_q.push_back(e);
        d_start = 0;
        d_abort = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string nm, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h",
                     nm, cyc_n, got, want);
        end
    endtask

    // Monitor: compares every registered output one step after each edge
    always @(posedge clk) begin
        #1;
        cyc_n++;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("busy", 16'(b.busy), 16'(e.busy));
            chk("done", 16'(b.done), 16'(e.done));
            chk("coils", 16'(b.coils), 16'(e.coils));
            chk("position", b.position, e.position);
            chk("busy_and_done", 16'(b.busy & b.done), 16'd0);
        end
    end

    task automatic defaults();
        d_rst = 1; d_en = 1; d_mode = 2'b10; d_sd = 0; d_per = 0;
        d_start = 0; d_steps = 0; d_abort = 0;
    endtask

    task automatic do_reset();
        d_rst = 0;
        run(2);
        d_rst = 1;
    endtask

    initial begin
        defaults();
        b.en = 0; b.mode = 0; b.sentido = 0; b.period = '0;
        b.start = 0; b.steps = '0; b.abort = 0; rst = 0;
        m_busy = 0; m_rem = 0; m_wait = 0; m_phase = 0; m_pos = 0;

        // Eight half-steps forward, one per cycle
        do_reset();
        run(1);
        d_start = 1; d_steps = 8;
        run(14);

        // Full-step reverse from idx 0, one tick per 4 cycles
        do_reset();
        d_mode = 2'b01; d_sd = 1; d_per = 3;
        d_start = 1; d_steps = 3;
        run(18);

        // Abort after four ticks
        defaults();
        d_per = 2; d_start = 1; d_steps = 10;
        run(13);
        d_abort = 1;
        run(6);

        // Enable dropped mid-move
        d_per = 1; d_start = 1; d_steps = 6;
        run(5);
        d_en = 0;
        run(20);
        d_en = 1;
        run(15);

        // Zero-step move, and start while busy
        d_start = 1; d_steps = 0;
        run(3);
        d_start = 1; d_steps = 5; d_per = 1;
        run(3);
        d_start = 1; d_steps = 40;
        run(12);

        // Reset mid-move
        d_mode = 2'b00; d_start = 1; d_steps = 20; d_per = 0;
        run(5);
        d_rst = 0;
        run(1);
        d_rst = 1;
        run(4);

        // Wave mode wrap-around and position underflow
        d_sd = 1; d_start = 1; d_steps = 12;
        run(16);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            d_en    = ($urandom_range(0, 15) != 0);
            d_rst   = ($urandom_range(0, 399) != 0);
            d_abort = ($urandom_range(0, 59) == 0);
            d_start = ($urandom_range(0, 3) == 0);
            d_steps = $urandom_range(0, 12);
            if ($urandom_range(0, 7) == 0) d_sd = 1'($urandom);
            if ($urandom_range(0, 15) == 0) d_mode = 2'($urandom);
            if ($urandom_range(0, 31) == 0) d_per = $urandom_range(0, 3);
            cyc();
        end

        defaults();
        run(3);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
